// File: rtl/piso_serializer.sv
// Parallel-in, serial-out transmitter: takes a WIDTH-bit word over valid/ready
// and streams it one bit per enabled clock, with first/last-bit framing strobes.
module piso_serializer #(
   parameter int WIDTH     = 8,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load_valid,
   output logic             load_ready,
   input  logic [WIDTH-1:0] load_data,
   input  logic             shift_en,
   output logic             dout,
   output logic             dout_valid,
   output logic             frame_start,
   output logic             frame_done
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   state_t           state_r, state_s;
   logic [WIDTH-1:0] sreg_r, sreg_s;
   logic [CW-1:0]    cnt_r, cnt_s;
   logic             dout_r, dout_s;
   logic             dv_r, dv_s;
   logic             fs_r, fs_s;
   logic             fd_r, fd_s;
   logic             ready_s;
   logic             accept_s;

   // The bit at the output end of a word for the configured bit order.
   function automatic logic head_bit(input logic [WIDTH-1:0] w);
      if (MSB_FIRST) begin
         return w[WIDTH-1];
      end else begin
         return w[0];
      end
   endfunction

   function automatic logic [WIDTH-1:0] shift_word(input logic [WIDTH-1:0] w);
      if (MSB_FIRST) begin
         return {w[WIDTH-2:0], 1'b0};
      end else begin
         return {1'b0, w[WIDTH-1:1]};
      end
   endfunction

   // Ready is only offered while idle or while the final bit is being consumed.
   always_comb begin
      ready_s = 1'b0;
      case (state_r)
         IDLE:    ready_s = 1'b1;
         SHIFT:   ready_s = shift_en && (cnt_r == '0);
         default: ready_s = 1'b0;
      endcase
      accept_s = load_valid && ready_s;
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Next-state logic.
   always_comb begin
      state_s = state_r;
      case (state_r)
         IDLE: begin
            if (accept_s) begin
               state_s = SHIFT;
            end else begin
               state_s = IDLE;
            end
         end
         SHIFT: begin
            if (shift_en && (cnt_r == '0) && !accept_s) begin
               state_s = IDLE;
            end else begin
               state_s = SHIFT;
            end
         end
         default: state_s = IDLE;
      endcase
   end

   // Datapath and strobe next values; a reload on the last bit keeps dout_valid high.
   always_comb begin
      sreg_s = sreg_r;
      cnt_s  = cnt_r;
      dout_s = dout_r;
      dv_s   = dv_r;
      fs_s   = fs_r;
      fd_s   = fd_r;
      if (accept_s) begin
         sreg_s = load_data;
         cnt_s  = CW'(WIDTH - 1);
         dout_s = head_bit(load_data);
         dv_s   = 1'b1;
         fs_s   = 1'b1;
         fd_s   = 1'b0;
      end else if ((state_r == SHIFT) && shift_en) begin
         if (cnt_r != '0) begin
            sreg_s = shift_word(sreg_r);
            cnt_s  = cnt_r - 1'b1;
            dout_s = head_bit(shift_word(sreg_r));
            fs_s   = 1'b0;
            fd_s   = (cnt_r == CW'(1));
         end else begin
            sreg_s = '0;
            cnt_s  = '0;
            dout_s = 1'b0;
            dv_s   = 1'b0;
            fs_s   = 1'b0;
            fd_s   = 1'b0;
         end
      end else begin
         sreg_s = sreg_r;
      end
   end

   // Datapath and output registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sreg_r <= '0;
         cnt_r  <= '0;
         dout_r <= 1'b0;
         dv_r   <= 1'b0;
         fs_r   <= 1'b0;
         fd_r   <= 1'b0;
      end else begin
         sreg_r <= sreg_s;
         cnt_r  <= cnt_s;
         dout_r <= dout_s;
         dv_r   <= dv_s;
         fs_r   <= fs_s;
         fd_r   <= fd_s;
      end
   end

   assign load_ready  = ready_s;
   assign dout        = dout_r;
   assign dout_valid  = dv_r;
   assign frame_start = fs_r;
   assign frame_done  = fd_r;

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: MSB-first and LSB-first instances share one stimulus
// stream and are checked every cycle against a word/bit-position reference model.
module tb_piso_serializer;

   logic       clk;
   logic       rst;
   logic       load_valid;
   logic [7:0] load_data;
   logic       shift_en;

   logic ready_m, dout_m, dv_m, fs_m, fd_m;
   logic ready_l, dout_l, dv_l, fs_l, fd_l;

   int checks = 0;
   int errors = 0;

   // reference model: current word, number of bits already consumed, frame active
   logic [7:0] m_word;
   int         m_pos;
   logic       m_active;

   // qualified (dout_valid & shift_en) bit histories, first bit ends up most significant
   logic [63:0] col_m, col_l;

   piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_m (
      .clk(clk), .rst(rst), .load_valid(load_valid), .load_ready(ready_m),
      .load_data(load_data), .shift_en(shift_en), .dout(dout_m),
      .dout_valid(dv_m), .frame_start(fs_m), .frame_done(fd_m)
   );

   piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_l (
      .clk(clk), .rst(rst), .load_valid(load_valid), .load_ready(ready_l),
      .load_data(load_data), .shift_en(shift_en), .dout(dout_l),
      .dout_valid(dv_l), .frame_start(fs_l), .frame_done(fd_l)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check1(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic check16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_outputs_zero(input string tag);
      check1({tag, "_dout_m"}, dout_m, 1'b0);
      check1({tag, "_dv_m"}, dv_m, 1'b0);
      check1({tag, "_fs_m"}, fs_m, 1'b0);
      check1({tag, "_fd_m"}, fd_m, 1'b0);
      check1({tag, "_dout_l"}, dout_l, 1'b0);
      check1({tag, "_dv_l"}, dv_l, 1'b0);
      check1({tag, "_fs_l"}, fs_l, 1'b0);
      check1({tag, "_fd_l"}, fd_l, 1'b0);
   endtask

   // One clock: drive at negedge, check ready, advance model at posedge, check outputs.
   task automatic step(input logic v, input logic [7:0] d, input logic se);
      logic exp_ready;
      logic act;
      @(negedge clk);
      load_valid = v;
      load_data  = d;
      shift_en   = se;
      #1;
      exp_ready = !m_active || (se && (m_pos == 7));
      check1("load_ready_m", ready_m, exp_ready);
      check1("load_ready_l", ready_l, exp_ready);
      if (dv_m && se) col_m = {col_m[62:0], dout_m};
      if (dv_l && se) col_l = {col_l[62:0], dout_l};
      @(posedge clk);
      if (m_active && se) begin
         m_pos++;
         if (m_pos == 8) m_active = 1'b0;
      end
      if (v && exp_ready) begin
         m_active = 1'b1;
         m_word   = d;
         m_pos    = 0;
      end
      #1;
      act = m_active;
      check1("dout_valid_m", dv_m, act);
      check1("dout_valid_l", dv_l, act);
      check1("dout_m", dout_m, act ? m_word[7 - m_pos] : 1'b0);
      check1("dout_l", dout_l, act ? m_word[m_pos] : 1'b0);
      check1("frame_start_m", fs_m, act && (m_pos == 0));
      check1("frame_start_l", fs_l, act && (m_pos == 0));
      check1("frame_done_m", fd_m, act && (m_pos == 7));
      check1("frame_done_l", fd_l, act && (m_pos == 7));
   endtask

   initial begin
      rst        = 1'b1;
      load_valid = 1'b0;
      load_data  = 8'h00;
      shift_en   = 1'b0;
      m_word     = 8'h00;
      m_pos      = 0;
      m_active   = 1'b0;
      col_m      = 64'h0;
      col_l      = 64'h0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check_outputs_zero("reset");
      check1("reset_ready_m", ready_m, 1'b1);

      // single frame A5 with shift_en held high
      step(1'b1, 8'hA5, 1'b1);
      repeat (8) step(1'b0, 8'h00, 1'b1);
      check16("a5_msb_bits", {8'h00, col_m[7:0]}, 16'h00A5);
      check16("a5_lsb_bits", {8'h00, col_l[7:0]}, 16'h00A5);

      // 01: LSB-first sequence is 1,0,0,0,0,0,0,0
      step(1'b1, 8'h01, 1'b1);
      repeat (8) step(1'b0, 8'h00, 1'b1);
      check16("01_msb_bits", {8'h00, col_m[7:0]}, 16'h0001);
      check16("01_lsb_bits", {8'h00, col_l[7:0]}, 16'h0080);

      // back-to-back F0 then 0F with load_valid held high
      step(1'b1, 8'hF0, 1'b1);
      repeat (8) step(1'b1, 8'h0F, 1'b1);
      repeat (9) step(1'b0, 8'h00, 1'b1);
      check16("b2b_msb_bits", col_m[15:0], 16'hF00F);
      check16("b2b_lsb_bits", col_l[15:0], 16'h0FF0);

      // stall for 3 cycles while the third bit of C3 is on dout
      step(1'b1, 8'hC3, 1'b1);
      repeat (2) step(1'b0, 8'h00, 1'b1);
      repeat (3) step(1'b1, 8'h99, 1'b0);
      repeat (7) step(1'b0, 8'h00, 1'b1);
      check16("stall_msb_bits", {8'h00, col_m[7:0]}, 16'h00C3);
      check16("stall_lsb_bits", {8'h00, col_l[7:0]}, 16'h00C3);

      // asynchronous reset in the middle of an FF frame
      step(1'b1, 8'hFF, 1'b1);
      repeat (3) step(1'b0, 8'h00, 1'b1);
      @(negedge clk);
      load_valid = 1'b0;
      #2;
      rst = 1'b1;
      #1;
      check_outputs_zero("midreset");
      m_active = 1'b0;
      m_pos    = 0;
      @(negedge clk);
      rst = 1'b0;
      step(1'b1, 8'h81, 1'b1);
      repeat (8) step(1'b0, 8'h00, 1'b1);
      check16("after_reset_msb_bits", {8'h00, col_m[7:0]}, 16'h0081);
      check16("after_reset_lsb_bits", {8'h00, col_l[7:0]}, 16'h0081);

      // backpressure: 55 offered for the whole 3C frame, accepted only on the last bit
      step(1'b1, 8'h3C, 1'b1);
      repeat (8) step(1'b1, 8'h55, 1'b1);
      repeat (9) step(1'b0, 8'h00, 1'b1);
      check16("bp_msb_bits", col_m[15:0], 16'h3C55);
      check16("bp_lsb_bits", col_l[15:0], 16'h3CAA);

      // randomized traffic against the model
      for (int i = 0; i < 500; i++) begin
         step(($urandom % 2) == 0, 8'($urandom), ($urandom % 4) != 0);
      end
      repeat (12) step(1'b0, 8'h00, 1'b1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
